seg7_scan_ctrl: RTL and testbench

Four-digit multiplexed 7-segment scan controller, downstream of the clock divider. Treats the divider output as a same-domain scan-rate strobe: edge-detects it, steps one digit per rising edge, and drives active-low anode and segment lines with an anti-ghosting blank gap between digits. Latches a coherent 16-bit hex value once per full scan so the display never tears.

---
 rtl/seg7_pkg.sv | 29 ++
 rtl/hex_to_7seg.sv | 11 +
 rtl/seg7_scan_ctrl.sv | 134 +++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared types and constants for the four-digit multiplexed 7-segment scan controller.
// All segment and anode values are active-low.
package seg7_pkg;

    typedef enum logic {
        S_BLANK = 1'b0,
        S_DRIVE = 1'b1
    } state_t;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [3:0] AN_OFF  = 4'hF;

    // Segment order {g,f,e,d,c,b,a}; index is the hex nibble value.
    localparam logic [6:0] HEX_SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

    // True when digit idx and every more-significant digit hold zero.
    // Digit 0 is never a leading zero.
    function automatic logic lz_digit(input logic [15:0] data, input logic [1:0] idx);
        logic [15:0] upper;
        upper    = data >> {idx, 2'b00};
        lz_digit = (idx != 2'd0) && (upper == 16'h0000);
    endfunction

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational hex nibble to active-low 7-segment pattern.
module hex_to_7seg
    import seg7_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    assign seg_o = HEX_SEG[nibble_i];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Four-digit 7-segment scanner: steps one digit per rising edge of the scan strobe,
// inserts a blank gap between digits and displays a once-per-scan snapshot of the data.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int BLANK_CYC = 8,
    parameter int N_DIGITS  = 4
) (
    input  logic        clk_10MHz_i,
    input  logic        rst_i,
    input  logic        clk_div_i,
    input  logic [15:0] data_i,
    input  logic [3:0]  dp_i,
    input  logic        blank_lz_i,
    output logic [3:0]  an_o,
    output logic [6:0]  seg_o,
    output logic        dp_o
);

    localparam int         CNT_W    = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (BLANK_CYC > 0) ? CNT_W'(BLANK_CYC - 1) : '0;
    localparam logic [1:0] IDX_LAST = 2'(N_DIGITS - 1);

    logic             clk_div_q;
    logic             tick;

    state_t           state_q,     state_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic [1:0]       idx_q,       idx_d;
    logic [15:0]      snap_data_q, snap_data_d;
    logic [3:0]       snap_dp_q,   snap_dp_d;
    logic             snap_lz_q,   snap_lz_d;

    logic [3:0]       an_q,  an_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q,  dp_d;

    logic [3:0]       cur_nibble;
    logic [6:0]       cur_seg;
    logic             cur_lz;

    assign tick = clk_div_i & ~clk_div_q;

    // Next-state logic. A tick always restarts the gap, even mid-gap.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        snap_data_d = snap_data_q;
        snap_dp_d   = snap_dp_q;
        snap_lz_d   = snap_lz_q;

        if (tick) begin
            idx_d = (idx_q == IDX_LAST) ? 2'd0 : idx_q + 2'd1;
            cnt_d = '0;
            if (idx_q == IDX_LAST) begin
                snap_data_d = data_i;
                snap_dp_d   = dp_i;
                snap_lz_d   = blank_lz_i;
            end
            state_d = (BLANK_CYC == 0) ? S_DRIVE : S_BLANK;
        end else begin
            case (state_q)
                S_BLANK: begin
                    if (BLANK_CYC == 0 || cnt_q == CNT_LAST) begin
                        state_d = S_DRIVE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_DRIVE: begin
                    state_d = S_DRIVE;
                end
                default: begin
                    state_d = S_BLANK;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Outputs are computed from next-state values so the registered pins line up
    // with the state they describe.
    assign cur_nibble = snap_data_d[{idx_d, 2'b00} +: 4];
    assign cur_lz     = snap_lz_d & lz_digit(snap_data_d, idx_d);

    hex_to_7seg u_hex_to_7seg (
        .nibble_i (cur_nibble),
        .seg_o    (cur_seg)
    );

    always_comb begin
        an_d  = AN_OFF;
        seg_d = SEG_OFF;
        dp_d  = 1'b1;
        if (state_d == S_DRIVE) begin
            an_d  = ~(4'b0001 << idx_d);
            seg_d = cur_lz ? SEG_OFF : cur_seg;
            dp_d  = ~snap_dp_d[idx_d];
        end
    end

    always_ff @(posedge clk_10MHz_i) begin
        if (rst_i) begin
            clk_div_q   <= 1'b0;
            state_q     <= S_BLANK;
            cnt_q       <= '0;
            idx_q       <= 2'd0;
            snap_data_q <= 16'h0000;
            snap_dp_q   <= 4'h0;
            snap_lz_q   <= 1'b0;
            an_q        <= AN_OFF;
            seg_q       <= SEG_OFF;
            dp_q        <= 1'b1;
        end else begin
            clk_div_q   <= clk_div_i;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            snap_data_q <= snap_data_d;
            snap_dp_q   <= snap_dp_d;
            snap_lz_q   <= snap_lz_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
        end
    end

    assign an_o  = an_q;
    assign seg_o = seg_q;
    assign dp_o  = dp_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: two instances (8-cycle gap and no gap) share stimulus and
// are compared every cycle against a timing-rule model of the scanner.
module tb_seg7_scan_ctrl;

    localparam int BLANK_A = 8;
    localparam int BLANK_B = 0;

    localparam logic [6:0] SEG_TAB [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        div = 1'b0;
    logic [15:0] data = 16'h0000;
    logic [3:0]  dp = 4'h0;
    logic        lz = 1'b0;

    logic [3:0]  an_a, an_b;
    logic [6:0]  seg_a, seg_b;
    logic        dp_a, dp_b;

    int n_cmp  = 0;
    int n_fail = 0;

    // Model: digit index, snapshot, and cycles elapsed since the last step event.
    int          m_idx      = 0;
    logic [15:0] m_snap     = 16'h0000;
    logic [3:0]  m_sdp      = 4'h0;
    logic        m_slz      = 1'b0;
    int          m_since    = 0;
    bit          m_from_rst = 1'b1;
    logic        m_prev_div = 1'b0;
    bit          armed      = 1'b0;
    int          ph         = 0;

    always #50 clk = ~clk;

    seg7_scan_ctrl #(.BLANK_CYC(BLANK_A), .N_DIGITS(4)) dut_a (
        .clk_10MHz_i (clk),
        .rst_i       (rst),
        .clk_div_i   (div),
        .data_i      (data),
        .dp_i        (dp),
        .blank_lz_i  (lz),
        .an_o        (an_a),
        .seg_o       (seg_a),
        .dp_o        (dp_a)
    );

    seg7_scan_ctrl #(.BLANK_CYC(BLANK_B), .N_DIGITS(4)) dut_b (
        .clk_10MHz_i (clk),
        .rst_i       (rst),
        .clk_div_i   (div),
        .data_i      (data),
        .dp_i        (dp),
        .blank_lz_i  (lz),
        .an_o        (an_b),
        .seg_o       (seg_b),
        .dp_o        (dp_b)
    );

    function automatic bit leading_zero(input int k);
        if (!m_slz || k == 0) return 1'b0;
        for (int j = k; j < 4; j++) begin
            if (m_snap[j*4 +: 4] != 4'h0) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic check_one(input string tag, input int b, input logic [3:0] an,
                             input logic [6:0] seg, input logic d);
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp;
        // After reset the first registered cycle is always blank, even with no gap.
        if (m_since < b || (m_from_rst && m_since == 0)) begin
            e_an  = 4'hF;
            e_seg = 7'h7F;
            e_dp  = 1'b1;
        end else begin
            e_an        = 4'hF;
            e_an[m_idx] = 1'b0;
            e_seg       = leading_zero(m_idx) ? 7'h7F : SEG_TAB[m_snap[m_idx*4 +: 4]];
            e_dp        = ~m_sdp[m_idx];
        end
        n_cmp++;
        assert (an === e_an) else begin
            n_fail++;
            $error("FAIL %s an_o: observed %h expected %h", tag, an, e_an);
        end
        n_cmp++;
        assert (seg === e_seg) else begin
            n_fail++;
            $error("FAIL %s seg_o: observed %h expected %h (idx %0d)", tag, seg, e_seg, m_idx);
        end
        n_cmp++;
        assert (d === e_dp) else begin
            n_fail++;
            $error("FAIL %s dp_o: observed %b expected %b", tag, d, e_dp);
        end
    endtask

    task automatic model_step();
        bit tick;
        if (rst) begin
            m_idx      = 0;
            m_snap     = 16'h0000;
            m_sdp      = 4'h0;
            m_slz      = 1'b0;
            m_since    = 0;
            m_from_rst = 1'b1;
            m_prev_div = 1'b0;
        end else begin
            tick       = div && !m_prev_div;
            m_prev_div = div;
            if (tick) begin
                if (m_idx == 3) begin
                    m_snap = data;
                    m_sdp  = dp;
                    m_slz  = lz;
                end
                m_idx      = (m_idx + 1) % 4;
                m_since    = 0;
                m_from_rst = 1'b0;
            end else if (m_since < 1000) begin
                m_since++;
            end
        end
    endtask

    // One clock cycle: check outputs at the falling edge, then apply inputs for the next edge.
    task automatic cyc(input logic r, input logic d);
        @(negedge clk);
        if (armed) begin
            check_one("gap8", BLANK_A, an_a, seg_a, dp_a);
            check_one("gap0", BLANK_B, an_b, seg_b, dp_b);
        end
        rst = r;
        div = d;
        model_step();
        @(posedge clk);
        #1;
        if (r) armed = 1'b1;
    endtask

    task automatic run(input int n, input int per);
        for (int i = 0; i < n; i++) begin
            cyc(1'b0, 1'((ph % per) < per / 2));
            ph++;
        end
    endtask

    initial begin
        int per;
        int len;
        logic [15:0] mask;

        // Reset held with the strobe toggling.
        cyc(1'b1, 1'b1);
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b1);

        // Full scans; strobe is high on release so the first cycle is a step.
        data = 16'h12AF; dp = 4'h0; lz = 1'b0; ph = 0;
        run(200, 20);
        dp = 4'($urandom_range(0, 15));
        run(160, 20);

        // Leading-zero suppression on and off.
        data = 16'h0050; lz = 1'b1;
        run(200, 20);
        lz = 1'b0;
        run(160, 20);

        // Data change mid-scan must wait for the next wrap.
        data = 16'h1111;
        run(160, 20);
        for (int i = 0; i < 100 && m_idx != 1; i++) run(1, 20);
        data = 16'h2222;
        run(200, 20);

        // Dense strobes, then normal spacing again.
        run(80, 4);
        run(200, 20);
        run(40, 2);
        run(100, 20);

        // Reset while digit 2 is being driven.
        for (int i = 0; i < 200 && !(m_idx == 2 && m_since >= BLANK_A + 2); i++) run(1, 20);
        cyc(1'b1, 1'b0);
        ph = 0;
        run(100, 20);

        // Randomized segments: strobe period, data with zero-heavy upper digits, stray resets.
        for (int s = 0; s < 60; s++) begin
            case ($urandom_range(0, 4))
                0: mask = 16'hFFFF;
                1: mask = 16'h0FFF;
                2: mask = 16'h00FF;
                3: mask = 16'h000F;
                default: mask = 16'h0000;
            endcase
            data = 16'($urandom) & mask;
            dp   = 4'($urandom_range(0, 15));
            lz   = 1'($urandom_range(0, 1));
            per  = $urandom_range(2, 30);
            len  = $urandom_range(20, 150);
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 49) == 0) data = 16'($urandom) & mask;
                if ($urandom_range(0, 299) == 0) begin
                    cyc(1'b1, 1'($urandom_range(0, 1)));
                end else if ($urandom_range(0, 9) == 0) begin
                    cyc(1'b0, 1'($urandom_range(0, 1)));
                end else begin
                    cyc(1'b0, 1'((ph % per) < per / 2));
                    ph++;
                end
            end
        end
        run(4, 20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
